// File: rtl/fp_align_shift.sv
// Floating-point mantissa alignment: routes the larger-exponent operand to the big path and right-shifts the other with sticky.
// Optional macro FP_ALIGN_BARREL_EN replaces the serial one-bit-per-cycle shifter with a single-cycle barrel shift.
module fp_align_shift #(
    parameter int FRAC_W = 26
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        exp1,
    input  logic [7:0]        exp2,
    input  logic [FRAC_W-1:0] frac1,
    input  logic [FRAC_W-1:0] frac2,
    input  logic [7:0]        u_diff,
    input  logic              cmp_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        exp_max,
    output logic [FRAC_W-1:0] frac_big,
    output logic [FRAC_W-1:0] frac_small,
    output logic              sticky,
    output logic              swapped
);
    localparam int CNT_W = $clog2(FRAC_W + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_init;
    logic [7:0]        big_exp;
    logic [FRAC_W-1:0] big_src;
    logic [FRAC_W-1:0] small_src;

    // Shifting by FRAC_W+1 already empties the mantissa into sticky, so larger distances saturate there.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [7:0] d);
        if (int'(d) > FRAC_W + 1) return CNT_W'(FRAC_W + 1);
        return CNT_W'(d);
    endfunction

`ifdef FP_ALIGN_BARREL_EN
    // Returns {sticky, shifted}; matches exactly what n serial single-bit shifts would produce.
    function automatic logic [FRAC_W:0] align_full(input logic [FRAC_W-1:0] src,
                                                   input logic [CNT_W-1:0]  n);
        logic st;
        st = 1'b0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (i < int'(n)) st = st | src[i];
        end
        return {st, src >> n};
    endfunction
`endif

    always_comb begin
        big_exp   = cmp_out ? exp2  : exp1;
        big_src   = cmp_out ? frac2 : frac1;
        small_src = cmp_out ? frac1 : frac2;
        cnt_init  = sat_cnt(u_diff);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            swapped    <= 1'b0;
            sticky     <= 1'b0;
            cnt        <= '0;
            exp_max    <= '0;
            frac_big   <= '0;
            frac_small <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        swapped  <= cmp_out;
                        exp_max  <= big_exp;
                        frac_big <= big_src;
                        cnt      <= cnt_init;
                        in_ready <= 1'b0;
`ifdef FP_ALIGN_BARREL_EN
                        {sticky, frac_small} <= align_full(small_src, cnt_init);
                        state     <= DONE;
                        out_valid <= 1'b1;
`else
                        frac_small <= small_src;
                        sticky     <= 1'b0;
                        if (cnt_init == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
`endif
                    end
                end
                SHIFT: begin
                    frac_small <= frac_small >> 1;
                    sticky     <= sticky | frac_small[0];
                    cnt        <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_shift.sv
// Directed bench for fp_align_shift: scoreboard of expected alignments, latency, stall and reset-abort behaviour.
module tb_fp_align_shift;
    localparam int FW = 26;

    logic          CLK;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    exp1;
    logic [7:0]    exp2;
    logic [FW-1:0] frac1;
    logic [FW-1:0] frac2;
    logic [7:0]    u_diff;
    logic          cmp_out;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    exp_max;
    logic [FW-1:0] frac_big;
    logic [FW-1:0] frac_small;
    logic          sticky;
    logic          swapped;

    fp_align_shift #(.FRAC_W(FW)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .exp1(exp1), .exp2(exp2), .frac1(frac1), .frac2(frac2),
        .u_diff(u_diff), .cmp_out(cmp_out), .out_valid(out_valid), .out_ready(out_ready),
        .exp_max(exp_max), .frac_big(frac_big), .frac_small(frac_small),
        .sticky(sticky), .swapped(swapped)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]    e;
        logic [FW-1:0] fb;
        logic [FW-1:0] fs;
        logic          st;
        logic          sw;
        int            lat;
    } res_t;

    res_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: bit-serial alignment, one shifted-out bit at a time.
    function automatic res_t model(input logic [7:0] e1, input logic [7:0] e2,
                                   input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                                   input logic [7:0] ud, input logic cm);
        res_t r;
        logic [FW-1:0] s;
        int n;
        r.sw = cm;
        r.e  = cm ? e2 : e1;
        r.fb = cm ? f2 : f1;
        s    = cm ? f1 : f2;
        n    = (int'(ud) > FW + 1) ? FW + 1 : int'(ud);
        r.st = 1'b0;
        for (int i = 0; i < n; i++) begin
            r.st = r.st | s[0];
            s    = s >> 1;
        end
        r.fs = s;
`ifdef FP_ALIGN_BARREL_EN
        r.lat = 1;
`else
        r.lat = 1 + n;
`endif
        return r;
    endfunction

    task automatic drive(input logic [7:0] e1, input logic [7:0] e2,
                         input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                         input logic [7:0] ud, input logic cm);
        exp1 = e1; exp2 = e2; frac1 = f1; frac2 = f2; u_diff = ud; cmp_out = cm;
        in_valid = 1'b1;
    endtask

    // Presents one operand pair in IDLE, records its expected result, releases in_valid after capture unless keep.
    task automatic issue(input logic [7:0] e1, input logic [7:0] e2,
                         input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                         input logic [7:0] ud, input logic cm, input bit keep);
        @(negedge CLK);
        drive(e1, e2, f1, f2, ud, cm);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        sbq.push_back(model(e1, e2, f1, f2, ud, cm));
        @(posedge CLK);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic collect(output res_t got);
        res_t e;
        int lat;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!out_valid && lat < 40);
        got.e = exp_max; got.fb = frac_big; got.fs = frac_small;
        got.st = sticky; got.sw = swapped; got.lat = lat;
        check("out_valid", 64'(out_valid), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("sb_depth", 64'(sbq.size()), 64'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("latency", 64'(lat), 64'(e.lat));
            check("exp_max", 64'(exp_max), 64'(e.e));
            check("frac_big", 64'(frac_big), 64'(e.fb));
            check("frac_small", 64'(frac_small), 64'(e.fs));
            check("sticky", 64'(sticky), 64'(e.st));
            check("swapped", 64'(swapped), 64'(e.sw));
        end
    endtask

    task automatic consume();
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        @(negedge CLK);
        check("consume_valid", 64'(out_valid), 64'd0);
        check("consume_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_exp_max"}, 64'(exp_max), 64'd0);
        check({tag, "_frac_big"}, 64'(frac_big), 64'd0);
        check({tag, "_frac_small"}, 64'(frac_small), 64'd0);
        check({tag, "_sticky"}, 64'(sticky), 64'd0);
        check({tag, "_swapped"}, 64'(swapped), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        res_t held;
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp1 = '0; exp2 = '0; frac1 = '0; frac2 = '0; u_diff = '0; cmp_out = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_state("reset");
        RST = 1'b0;

        // Worked example: diff 3, no swap
        issue(8'h85, 8'h82, 26'h2000000, 26'h3000005, 8'd3, 1'b0, 1'b0);
        collect(r);
        check("ex1_frac_small", 64'(r.fs), 64'h0600000);
        check("ex1_sticky", 64'(r.st), 64'd1);
        check("ex1_exp", 64'(r.e), 64'h85);
        consume();

        // Swapped operands, diff 15
        issue(8'h70, 8'h7F, 26'h2ABCDEF, 26'h3123456, 8'd15, 1'b1, 1'b0);
        collect(r);
        check("ex2_frac_big", 64'(r.fb), 64'h3123456);
        check("ex2_swapped", 64'(r.sw), 64'd1);
        consume();

        // Equal exponents
        issue(8'h7F, 8'h7F, 26'h2345678, 26'h3456789, 8'd0, 1'b0, 1'b0);
        collect(r);
        check("eq_frac_small", 64'(r.fs), 64'h3456789);
        check("eq_sticky", 64'(r.st), 64'd0);
        consume();

        // Huge difference saturates the shift
        issue(8'hFE, 8'h36, 26'h2000000, 26'h0000001, 8'd200, 1'b0, 1'b0);
        collect(r);
        check("huge_frac_small", 64'(r.fs), 64'd0);
        check("huge_sticky", 64'(r.st), 64'd1);
        consume();

        // Shift distances around the mantissa width
        issue(8'h90, 8'h90 - 8'd25, 26'h2000000, 26'h2000000, 8'd25, 1'b0, 1'b0);
        collect(r);
        check("d25_frac_small", 64'(r.fs), 64'd1);
        consume();
        issue(8'h40, 8'h5A, 26'h3FFFFFF, 26'h2000000, 8'd26, 1'b1, 1'b0);
        collect(r);
        consume();
        issue(8'h80, 8'h65, 26'h2000000, 26'h2000000, 8'd27, 1'b0, 1'b0);
        collect(r);
        consume();
        issue(8'h81, 8'h80, 26'h2000001, 26'h3000003, 8'd1, 1'b0, 1'b0);
        collect(r);
        consume();

        // Stall in DONE with a second request held on in_valid the whole time
        issue(8'h85, 8'h82, 26'h2000000, 26'h3000005, 8'd3, 1'b0, 1'b1);
        drive(8'h60, 8'h64, 26'h3FFFFF1, 26'h2222222, 8'd4, 1'b1);
        collect(held);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_frac_small", 64'(frac_small), 64'(held.fs));
            check("stall_exp", 64'(exp_max), 64'(held.e));
        end
        sbq.push_back(model(8'h60, 8'h64, 26'h3FFFFF1, 26'h2222222, 8'd4, 1'b1));
        consume();
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        collect(r);
        consume();

        // Reset aborts an operation in flight
        issue(8'h70, 8'h7F, 26'h2ABCDEF, 26'h3123456, 8'd15, 1'b1, 1'b0);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sbq.delete();
        @(negedge CLK);
        check_reset_state("abort");
        repeat (20) begin
            @(negedge CLK);
            check("abort_quiet", 64'(out_valid), 64'd0);
        end

        // Operation after abort still works
        issue(8'h85, 8'h82, 26'h2000000, 26'h3000005, 8'd3, 1'b0, 1'b0);
        collect(r);
        check("post_abort_frac_small", 64'(r.fs), 64'h0600000);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
